uio_bus_arbiter: RTL and testbench
==================================

// Module: uio_bus_arbiter
// PURPOSE
//  Shares the 8-bit bidirectional uio pad bus of the Tiny Tapeout user tile between N_REQ internal requesters.
//  Each grant drives the bus (uio_oe=FF) or samples it (uio_oe=00) for one requester.
//  Grants are round-robin with a bounded burst length.
//  Every change of owner passes through a one-cycle turnaround with uio_oe=00, so the pads are never driven by two owners on consecutive cycles.
//  Sits between the user logic and the uio_in/uio_out/uio_oe pads of the top-level tt_um wrapper.
// PARAMETERS
//  N_REQ      4  number of requesters (2..8)
//  MAX_BURST  4  max OWN cycles per grant while others wait; 0 = unlimited
// PORTS
//  clk          in   1        clock
//  rst          in   1        synchronous reset, active-high
//  ena          in   1        tile enable; 0 forces release and blocks new grants
//  req          in   N_REQ    request per requester, level, held until done
//  dir          in   N_REQ    1 = drive bus, 0 = sample bus; sampled at grant only
//  wdata        in   N_REQ*8  write data, requester i on bits [8i+7:8i]
//  gnt          out  N_REQ    one-hot grant, registered
//  busy         out  1        state != IDLE
//  uio_in       in   8        pad input path
//  uio_out      out  8        pad output path, registered
//  uio_oe       out  8        pad enable, registered, always 8'h00 or 8'hFF
//  rdata        out  8        registered sample of uio_in for the read owner
//  rdata_valid  out  1        1 for each cycle rdata holds a new sample
// BEHAVIOUR
//  Reset: state=IDLE, gnt=0, busy=0, uio_out=00, uio_oe=00, rdata=00, rdata_valid=0.
//   Round-robin pointer ptr=0, burst count=0.
//   rst overrides ena and every other input; it takes effect at the next edge from any state.
//  FSM states: IDLE, TURN, OWN.
//   IDLE -> TURN when ena && |req.
//   TURN -> OWN  when ena && |req.
//    Winner = first set req[i] scanning from ptr upward, with wrap.
//    dir[winner] is latched, gnt becomes one-hot, burst count is cleared.
//   TURN -> IDLE when !ena or req==0.
//   OWN  -> TURN on release, which is any of:
//    - req[owner]==0
//    - MAX_BURST!=0, burst count==MAX_BURST-1, and any other req set
//    On release: gnt=0 and ptr=owner+1 mod N_REQ.
//   Any state -> IDLE when ena==0: gnt=0 and uio_oe=00 at the next edge; ptr is unchanged.
//  Latency: req sampled high in IDLE at edge k -> gnt visible after edge k+1.
//  In OWN, write direction (latched dir=1):
//   At each edge, uio_oe<=FF and uio_out<=wdata[owner]; one-cycle pipeline.
//  In OWN, read direction (latched dir=0):
//   uio_oe<=00; rdata<=uio_in and rdata_valid<=1 at each edge.
//  In IDLE and TURN: uio_oe<=00, rdata_valid<=0; uio_out keeps its last value.
//  Burst count: increments each OWN cycle, saturates; when no other requester waits, ownership continues indefinitely.
//  Owner drops req in the same cycle others raise theirs: normal release via TURN; no back-to-back owners.
//  Changes to dir or unowned wdata while granted are ignored.
//  A lone requester re-requesting after release is regranted via TURN (ptr wrap still applies).
// TESTING
//  1 Reset: rst=1 for 2 cycles with req=F, ena=1
//    -> gnt=0, busy=0, uio_oe=00, uio_out=00, rdata_valid=0.
//  2 Write: ena=1, req=0001, dir[0]=1, wdata0=A5
//    -> gnt=0001 after 2 edges; uio_oe=FF, uio_out=A5 one edge later.
//    Then drop req0 -> one cycle with uio_oe=00 (TURN), then IDLE.
//  3 Round robin: req=1111 held, dir=1111, MAX_BURST=4
//    -> owners 0,1,2,3,0; each owns exactly 4 cycles with exactly 1 TURN cycle (uio_oe=00) between owners.
//  4 Read: req=0100, dir[2]=0, uio_in=3C
//    -> uio_oe=00, rdata=3C with rdata_valid=1 each OWN cycle; toggle dir[2] mid-grant -> uio_oe stays 00.
//  5 Enable drop: req0 owning a write, ena->0
//    -> next edge gnt=0, uio_oe=00, busy=0; no grant while ena=0; ena->1 -> regrant after 2 edges.
//  6 Mid-op reset: rst=1 during OWN with uio_oe=FF
//    -> next edge all outputs at reset values, ptr=0, req0 wins first after release of rst.

Source files
------------

// File: rtl/uio_bus_arbiter.sv
// uio_bus_arbiter: round-robin owner of the uio pad bus with bounded bursts
// and a one-cycle undriven turnaround between owners.
module uio_bus_arbiter #(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   dir,
    input  logic [N_REQ*8-1:0] wdata,
    output logic [N_REQ-1:0]   gnt,
    output logic               busy,
    input  logic [7:0]         uio_in,
    output logic [7:0]         uio_out,
    output logic [7:0]         uio_oe,
    output logic [7:0]         rdata,
    output logic               rdata_valid
);
    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_BURST + 1) + 1;
    localparam logic [CW-1:0] LAST = CW'(MAX_BURST == 0 ? 0 : MAX_BURST - 1);

    typedef enum logic [1:0] {IDLE, TURN, OWN} state_t;

    state_t        state;
    logic [PW-1:0] ptr, owner, win, nxt;
    logic [CW-1:0] cnt;
    logic          wr, rel, act;

    function automatic logic [PW-1:0] pick(input logic [N_REQ-1:0] r, input logic [PW-1:0] p);
        logic [PW-1:0] j;
        pick = p;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            j = PW'((int'(p) + i) % N_REQ);
            if (r[j]) pick = j;
        end
    endfunction

    assign win  = pick(req, ptr);
    assign nxt  = owner == PW'(N_REQ - 1) ? '0 : owner + 1'b1;
    // cnt saturates at LAST so a long lone burst still yields once someone else asks
    assign rel  = !req[owner] || (MAX_BURST != 0 && cnt == LAST && |(req & ~gnt));
    assign act  = state == OWN && ena;
    assign busy = state != IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            gnt         <= '0;
            ptr         <= '0;
            owner       <= '0;
            wr          <= 1'b0;
            cnt         <= '0;
            uio_out     <= '0;
            uio_oe      <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
        end else begin
            uio_oe      <= {8{act && wr}};
            rdata_valid <= act && !wr;
            if (act && wr) uio_out <= wdata[{owner, 3'b000} +: 8];
            if (act && !wr) rdata <= uio_in;
            if (!ena) begin
                state <= IDLE;
                gnt   <= '0;
            end else begin
                case (state)
                    IDLE: if (|req) state <= TURN;
                    TURN: begin
                        if (|req) begin
                            state <= OWN;
                            owner <= win;
                            wr    <= dir[win];
                            gnt   <= N_REQ'(1) << win;
                            cnt   <= '0;
                        end else state <= IDLE;
                    end
                    OWN: begin
                        if (rel) begin
                            state <= TURN;
                            gnt   <= '0;
                            ptr   <= nxt;
                        end else if (cnt != LAST) cnt <= cnt + 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uio_bus_arbiter.sv
// tb_uio_bus_arbiter: directed stimulus against a cycle model of owner,
// turnaround and pad behaviour, plus hand-computed spot checks.
module tb_uio_bus_arbiter;
    localparam int N  = 4;
    localparam int MB = 4;

    logic           clk = 1'b0, rst = 1'b1, ena = 1'b1;
    logic [N-1:0]   req = '1, dir = '1;
    logic [N*8-1:0] wdata = '0;
    logic [7:0]     uio_in = '0;
    logic [N-1:0]   gnt;
    logic           busy, rdata_valid;
    logic [7:0]     uio_out, uio_oe, rdata;

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    uio_bus_arbiter #(.N_REQ(N), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .ena(ena), .req(req), .dir(dir), .wdata(wdata),
        .gnt(gnt), .busy(busy), .uio_in(uio_in), .uio_out(uio_out),
        .uio_oe(uio_oe), .rdata(rdata), .rdata_valid(rdata_valid)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // model: who owns the bus, whether a turnaround is pending, and what the pads should show
    int         m_own = -1, m_ptr = 0, m_run = 0, w;
    bit         m_turn = 0, m_drive = 0, armed = 0, e_rv = 0;
    logic [7:0] e_oe = '0, e_out = '0, e_rd = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_own = -1; m_turn = 0; m_ptr = 0; m_run = 0;
            e_oe = '0; e_out = '0; e_rd = '0; e_rv = 0; armed = 1;
        end else begin
            if (ena && m_own >= 0 && m_drive) begin
                e_oe  = 8'hFF;
                e_out = wdata[8*m_own +: 8];
            end else e_oe = 8'h00;
            e_rv = ena && m_own >= 0 && !m_drive;
            if (e_rv) e_rd = uio_in;
            if (!ena) begin
                m_own = -1; m_turn = 0;
            end else if (m_own >= 0) begin
                m_run++;
                if (!req[m_own] || (MB != 0 && m_run >= MB && (req & ~(N'(1) << m_own)) != 0)) begin
                    m_ptr = (m_own + 1) % N; m_own = -1; m_turn = 1;
                end
            end else if (m_turn) begin
                m_turn = 0;
                if (req != 0) begin
                    w = -1;
                    for (int k = 0; k < N; k++) if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                    m_own = w; m_drive = dir[w]; m_run = 0;
                end
            end else if (req != 0) m_turn = 1;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("gnt", 32'(gnt), m_own >= 0 ? 32'(1) << m_own : 32'd0);
            chk("busy", 32'(busy), 32'(m_own >= 0 || m_turn));
            chk("uio_oe", 32'(uio_oe), 32'(e_oe));
            chk("uio_out", 32'(uio_out), 32'(e_out));
            chk("rdata_valid", 32'(rdata_valid), 32'(e_rv));
            chk("rdata", 32'(rdata), 32'(e_rd));
        end
    end

    logic [N-1:0] gs[30];
    int own_q[$], len_q[$], gap_q[$];
    int cur, len, gap, idx;

    initial begin
        // reset held with everyone requesting
        tick(2);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_oe", 32'(uio_oe), 0);
        chk("rst_out", 32'(uio_out), 0);
        chk("rst_rv", 32'(rdata_valid), 0);

        // single write owner, then release
        rst = 1'b0; req = 4'b0001; dir = 4'b0001; wdata = 32'h0000_00A5;
        tick(1); chk("wr_turn_gnt", 32'(gnt), 0); chk("wr_turn_busy", 32'(busy), 1);
        tick(1); chk("wr_gnt", 32'(gnt), 1); chk("wr_oe_lag", 32'(uio_oe), 0);
        tick(1); chk("wr_oe", 32'(uio_oe), 32'hFF); chk("wr_out", 32'(uio_out), 32'hA5);
        req = '0;
        tick(1); chk("wr_rel_gnt", 32'(gnt), 0); chk("wr_rel_busy", 32'(busy), 1);
        tick(1); chk("wr_idle_busy", 32'(busy), 0); chk("wr_idle_oe", 32'(uio_oe), 0);

        // round robin with everyone requesting
        rst = 1'b1; tick(1); rst = 1'b0;
        req = 4'b1111; dir = 4'b1111; wdata = 32'h4433_2211;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            gs[i] = gnt;
        end
        req = '0;
        cur = -1; len = 0; gap = 0;
        for (int i = 0; i < 30; i++) begin
            if (gs[i] == 0) begin
                if (cur >= 0) begin
                    own_q.push_back(cur); len_q.push_back(len); cur = -1; gap = 0;
                end
                gap++;
            end else begin
                idx = -1;
                for (int k = 0; k < N; k++) if (gs[i][k]) idx = k;
                if (cur >= 0 && idx != cur) begin
                    own_q.push_back(cur); len_q.push_back(len); gap_q.push_back(0); cur = -1;
                end
                if (cur < 0) begin
                    if (own_q.size() > 0 && gap > 0) gap_q.push_back(gap);
                    cur = idx; len = 0;
                end
                len++;
            end
        end
        chk("rr_run_count", 32'(own_q.size() >= 5), 1);
        if (own_q.size() >= 5 && gap_q.size() >= 4) begin
            for (int k = 0; k < 5; k++) chk($sformatf("rr_owner%0d", k), 32'(own_q[k]), 32'(k % 4));
            for (int k = 0; k < 4; k++) chk($sformatf("rr_len%0d", k), 32'(len_q[k]), 4);
            for (int k = 0; k < 4; k++) chk($sformatf("rr_gap%0d", k), 32'(gap_q[k]), 1);
        end
        tick(3);

        // read owner, dir toggled mid-grant, then burst limit after a long lone burst
        req = 4'b0100; dir = 4'b0000; uio_in = 8'h3C;
        tick(2); chk("rd_gnt", 32'(gnt), 4);
        tick(1); chk("rd_oe", 32'(uio_oe), 0); chk("rd_rv", 32'(rdata_valid), 1); chk("rd_data", 32'(rdata), 32'h3C);
        dir = 4'b0100; uio_in = 8'h5A;
        tick(1); chk("rd_dir_oe", 32'(uio_oe), 0); chk("rd_data2", 32'(rdata), 32'h5A);
        tick(2); chk("rd_dir_oe2", 32'(uio_oe), 0);
        req = 4'b0101;
        tick(1); chk("burst_rel", 32'(gnt), 0);
        tick(1); chk("burst_next", 32'(gnt), 1);
        req = '0;
        tick(3);

        // enable drop while a write owns the bus
        req = 4'b0001; dir = 4'b0001; wdata = 32'h0000_00C3;
        tick(3); chk("ena_gnt", 32'(gnt), 1); chk("ena_oe", 32'(uio_oe), 32'hFF); chk("ena_out", 32'(uio_out), 32'hC3);
        ena = 1'b0;
        tick(1); chk("ena0_gnt", 32'(gnt), 0); chk("ena0_oe", 32'(uio_oe), 0); chk("ena0_busy", 32'(busy), 0);
        tick(3); chk("ena0_hold_gnt", 32'(gnt), 0); chk("ena0_hold_busy", 32'(busy), 0);
        ena = 1'b1;
        tick(1); chk("ena1_turn", 32'(gnt), 0);
        tick(1); chk("ena1_gnt", 32'(gnt), 1);
        tick(1); chk("ena1_oe", 32'(uio_oe), 32'hFF);

        // reset mid-write; pointer returns to 0 so req0 beats req3
        rst = 1'b1; req = 4'b1001; dir = 4'b1001;
        tick(1);
        chk("mrst_gnt", 32'(gnt), 0); chk("mrst_busy", 32'(busy), 0); chk("mrst_oe", 32'(uio_oe), 0);
        chk("mrst_out", 32'(uio_out), 0); chk("mrst_rv", 32'(rdata_valid), 0); chk("mrst_rdata", 32'(rdata), 0);
        rst = 1'b0;
        tick(1); chk("mrst_turn", 32'(busy), 1);
        tick(1); chk("mrst_win", 32'(gnt), 1);
        tick(1); chk("mrst_oe2", 32'(uio_oe), 32'hFF); chk("mrst_out2", 32'(uio_out), 32'hC3);
        req = '0;
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
